// File: rtl/ecg_bitstream_packer_if.sv
// Handshake bundle between an ECG entropy encoder and the bitstream packer.
// The encoder side drives the master modport; the packer uses the slave modport.
interface ecg_bitstream_packer_if #(
  parameter int unsigned CODE_WIDTH = 50,
  parameter int unsigned SIZE_WIDTH = 6,
  parameter int unsigned SIGN_WIDTH = 4,
  parameter int unsigned OUT_WIDTH  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CODE_WIDTH-1:0] in_code;
  logic [SIZE_WIDTH-1:0] in_size;
  logic [SIGN_WIDTH-1:0] in_sign;
  logic [2:0]            in_sign_size;
  logic                  flush_req;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  flush_done;
  logic                  err_oversize;
  logic [31:0]           bits_written;

  modport master (
    output in_valid, in_code, in_size, in_sign, in_sign_size, flush_req, out_ready,
    input  in_ready, out_valid, out_data, flush_done, err_oversize, bits_written
  );

  modport slave (
    input  in_valid, in_code, in_size, in_sign, in_sign_size, flush_req, out_ready,
    output in_ready, out_valid, out_data, flush_done, err_oversize, bits_written
  );
endinterface

// File: rtl/ecg_bitstream_packer.sv
// Packs variable-length ECG codes MSB-first into fixed-width words, appending each
// group's deferred sign bits after the group's last code; supports flush with zero pad.
module ecg_bitstream_packer #(
  parameter int unsigned CODE_WIDTH = 50,
  parameter int unsigned SIZE_WIDTH = 6,
  parameter int unsigned SIGN_WIDTH = 4,
  parameter int unsigned NUM_ECG    = 4,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned BUF_WIDTH  = 128
) (
  input logic                   clk,
  input logic                   rst,
  ecg_bitstream_packer_if.slave bus
);
  localparam int unsigned FillW    = $clog2(BUF_WIDTH + 1);
  localparam int unsigned SignBufW = NUM_ECG * SIGN_WIDTH;
  localparam int unsigned SFillW   = $clog2(SignBufW + 1);
  localparam int unsigned CntW     = $clog2(NUM_ECG + 1);
  localparam logic [FillW-1:0] OutFill = FillW'(OUT_WIDTH);

  typedef enum logic [1:0] {StAccept, StAppendSign, StFlush} state_e;

  state_e                state_q, state_d;
  logic [BUF_WIDTH-1:0]  buf_q, buf_d;
  logic [FillW-1:0]      fill_q, fill_d;
  logic [SignBufW-1:0]   sign_q, sign_d;
  logic [SFillW-1:0]     sign_fill_q, sign_fill_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  err_q, err_d;
  logic [31:0]           bw_q, bw_d;

  logic [SIZE_WIDTH-1:0] code_size;
  logic [CODE_WIDTH-1:0] code_m;
  logic [SIGN_WIDTH-1:0] sign_m;
  logic                  oversize, ready, word_valid, xfer, pop, done;
  logic [BUF_WIDTH-1:0]  buf_pop;
  logic [FillW-1:0]      fill_pop;
  logic [OUT_WIDTH-1:0]  out_mask;

  // Right-aligned field of 'size' bits moved so its MSB lands 'at' bits below the buffer top.
  function automatic logic [BUF_WIDTH-1:0] place(input logic [BUF_WIDTH-1:0] val,
                                                 input int unsigned size,
                                                 input int unsigned at);
    logic [BUF_WIDTH-1:0] aligned;
    aligned = (size == 0) ? '0 : (val << (BUF_WIDTH - size));
    return aligned >> at;
  endfunction

  assign code_size = bus.in_size;
  assign code_m    = bus.in_code & ~({CODE_WIDTH{1'b1}} << code_size);
  assign sign_m    = bus.in_sign & ~({SIGN_WIDTH{1'b1}} << bus.in_sign_size);
  assign oversize  = (32'(code_size) > CODE_WIDTH) || (32'(bus.in_sign_size) > SIGN_WIDTH);

  assign ready      = (state_q == StAccept) && (32'(fill_q) <= BUF_WIDTH - CODE_WIDTH);
  assign word_valid = (32'(fill_q) >= OUT_WIDTH) || ((state_q == StFlush) && (fill_q != '0));
  assign xfer       = bus.in_valid && ready;
  assign pop        = word_valid && bus.out_ready;

  assign buf_pop  = pop ? (buf_q << OUT_WIDTH) : buf_q;
  assign fill_pop = pop ? ((fill_q > OutFill) ? (fill_q - OutFill) : '0) : fill_q;

  // Bits below fill are forced low, which doubles as the flush zero padding.
  assign out_mask = ~({OUT_WIDTH{1'b1}} >> fill_q);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_pop;
    fill_d      = fill_pop;
    sign_d      = sign_q;
    sign_fill_d = sign_fill_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    err_d       = err_q;
    bw_d        = bw_q;
    done        = 1'b0;

    unique case (state_q)
      StAccept: begin
        if (xfer) begin
          if (oversize) begin
            err_d = 1'b1;
          end else begin
            buf_d = buf_pop | place({{(BUF_WIDTH - CODE_WIDTH){1'b0}}, code_m},
                                    32'(code_size), 32'(fill_pop));
            fill_d      = fill_pop + FillW'(code_size);
            sign_d      = (sign_q << bus.in_sign_size) |
                          {{(SignBufW - SIGN_WIDTH){1'b0}}, sign_m};
            sign_fill_d = sign_fill_q + SFillW'(bus.in_sign_size);
            cnt_d       = cnt_q + CntW'(1);
            bw_d        = bw_q + 32'(code_size);
          end
        end
        if (32'(cnt_d) == NUM_ECG) begin
          state_d = StAppendSign;
          pend_d  = bus.flush_req;
        end else if (bus.flush_req) begin
          if (cnt_d != '0) begin
            state_d = StAppendSign;
            pend_d  = 1'b1;
          end else begin
            state_d = StFlush;
          end
        end
      end

      StAppendSign: begin
        if (32'(fill_pop) + 32'(sign_fill_q) <= BUF_WIDTH) begin
          buf_d = buf_pop | place({{(BUF_WIDTH - SignBufW){1'b0}}, sign_q},
                                  32'(sign_fill_q), 32'(fill_pop));
          fill_d      = fill_pop + FillW'(sign_fill_q);
          bw_d        = bw_q + 32'(sign_fill_q);
          sign_d      = '0;
          sign_fill_d = '0;
          cnt_d       = '0;
          pend_d      = 1'b0;
          state_d     = pend_q ? StFlush : StAccept;
        end
      end

      StFlush: begin
        // Covers both an empty flush and the pop of the final word.
        if (fill_pop == '0) begin
          done    = 1'b1;
          state_d = StAccept;
        end
      end

      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAccept;
      buf_q       <= '0;
      fill_q      <= '0;
      sign_q      <= '0;
      sign_fill_q <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      bw_q        <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      sign_q      <= sign_d;
      sign_fill_q <= sign_fill_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      bw_q        <= bw_d;
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = word_valid;
  assign bus.out_data     = buf_q[BUF_WIDTH-1 -: OUT_WIDTH] & out_mask;
  assign bus.flush_done   = done;
  assign bus.err_oversize = err_q;
  assign bus.bits_written = bw_q;
endmodule

// File: tb/tb_ecg_bitstream_packer.sv
// Directed table-driven bench for the ECG bitstream packer with a small bit-queue model
// for the long-code backpressure sequence.
module tb_ecg_bitstream_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecg_bitstream_packer_if bus ();
  ecg_bitstream_packer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [49:0] code;
    logic [5:0]  size;
    logic [3:0]  sign;
    logic [2:0]  ssize;
    logic        flush;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_bw;
    logic        exp_err;
  } vec_t;

  vec_t        vt[16];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got_q[$];
  int          fd_cnt     = 0;
  int          fd_pop_cnt = 0;
  bit          mq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (bus.flush_done) begin
        fd_cnt++;
        if (bus.out_valid && bus.out_ready) fd_pop_cnt++;
      end
    end
  end

  function automatic vec_t mk(input logic [49:0] code, input logic [5:0] size,
                              input logic [3:0] sign, input logic [2:0] ssize, input logic flush,
                              input logic rdy, input logic vld, input logic [31:0] bw,
                              input logic err);
    vec_t v;
    v.code = code; v.size = size; v.sign = sign; v.ssize = ssize; v.flush = flush;
    v.exp_ready = rdy; v.exp_valid = vld; v.exp_bw = bw; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input int idx, input logic [31:0] exp);
    if (idx < got_q.size()) begin
      chk(name, 64'(got_q[idx]), 64'(exp));
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: word missing, expected %0h", name, exp);
    end
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.in_code      = v.code;
    bus.in_size      = v.size;
    bus.in_sign      = v.sign;
    bus.in_sign_size = v.ssize;
    bus.flush_req    = v.flush;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(1), 64'(0));
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic run_vec(input int i);
    send(vt[i]);
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vt[i].exp_ready));
    chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vt[i].exp_valid));
    chk($sformatf("v%0d_bits_written", i), 64'(bus.bits_written), 64'(vt[i].exp_bw));
    chk($sformatf("v%0d_err", i), 64'(bus.err_oversize), 64'(vt[i].exp_err));
  endtask

  task automatic pulse_flush();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("flush_wait_timeout", 64'(1), 64'(0));
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (fd_cnt == base && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("flush_done_timeout", 64'(1), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(bus.out_data), 64'(0));
    chk({tag, "_bits_written"}, 64'(bus.bits_written), 64'(0));
    chk({tag, "_err"}, 64'(bus.err_oversize), 64'(0));
    chk({tag, "_flush_done"}, 64'(bus.flush_done), 64'(0));
  endtask

  task automatic mpush(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mq.push_back(v[i]);
  endtask

  function automatic logic [31:0] mword();
    logic [31:0] w = '0;
    for (int i = 31; i >= 0; i--) if (mq.size() > 0) w[i] = mq.pop_front();
    return w;
  endfunction

  initial begin
    int wb, fb, fpb, nw;
    vt[0]  = mk(50'h3FF, 10, 4'h1, 1, 0, 1, 0, 10, 0);
    vt[1]  = mk(50'h000, 10, 4'h1, 1, 0, 1, 0, 20, 0);
    vt[2]  = mk(50'h2AA, 10, 4'h1, 1, 0, 1, 0, 30, 0);
    vt[3]  = mk(50'h155, 10, 4'h1, 1, 0, 0, 1, 40, 0);
    vt[4]  = mk(50'h2_DEAD_BEEF_1234, 50, 4'h1, 1, 0, 1, 1, 50, 0);
    vt[5]  = mk(50'h1_5A5A_C3C3_0F0F, 50, 4'h0, 1, 0, 0, 1, 100, 0);
    vt[6]  = mk(50'h0, 51, 4'h0, 0, 0, 1, 0, 0, 1);
    vt[7]  = mk(50'hA5, 8, 4'h0, 0, 0, 1, 0, 8, 1);
    vt[8]  = mk(50'hA5, 8, 4'h0, 0, 0, 1, 0, 16, 1);
    vt[9]  = mk(50'hA5, 8, 4'h0, 0, 0, 1, 0, 24, 1);
    vt[10] = mk(50'hF, 4, 4'hF, 5, 0, 1, 0, 24, 1);
    vt[11] = mk(50'h7F, 7, 4'h2, 2, 0, 1, 0, 7, 0);
    vt[12] = mk(50'h01, 7, 4'h1, 2, 1, 0, 0, 14, 0);
    vt[13] = mk(50'hABCDE, 20, 4'h0, 0, 0, 1, 0, 20, 0);
    vt[14] = mk(50'h12345, 20, 4'h0, 0, 1, 0, 1, 40, 0);
    vt[15] = mk(50'hC3, 8, 4'h0, 0, 0, 1, 0, 8, 0);

    bus.in_valid = 1'b0; bus.in_code = '0; bus.in_size = '0; bus.in_sign = '0;
    bus.in_sign_size = '0; bus.flush_req = 1'b0; bus.out_ready = 1'b1;
    do_reset();
    chk_reset_state("por");

    // Empty flush: done pulse, no words.
    wb = got_q.size(); fb = fd_cnt;
    pulse_flush();
    wait_done(fb);
    chk("empty_flush_words", 64'(got_q.size() - wb), 64'(0));
    chk("empty_flush_done", 64'(fd_cnt - fb), 64'(1));

    // Full group of four 10-bit codes, then flush.
    bus.out_ready = 1'b1;
    wb = got_q.size(); fb = fd_cnt;
    for (int i = 0; i < 4; i++) run_vec(i);
    pulse_flush();
    wait_done(fb);
    chk("grp_words", 64'(got_q.size() - wb), 64'(2));
    chk_word("grp_word0", wb, 32'hFFC00AA9);
    chk_word("grp_word1", wb + 1, 32'h55F00000);
    chk("grp_bits_written", 64'(bus.bits_written), 64'(44));
    chk("grp_flush_done", 64'(fd_cnt - fb), 64'(1));

    // Backpressure with 50-bit codes.
    do_reset();
    bus.out_ready = 1'b0;
    wb = got_q.size(); fb = fd_cnt;
    for (int i = 4; i < 6; i++) run_vec(i);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(bus.in_ready), 64'(1));
    nw = 0;
    while (bus.out_valid && nw < 50) begin
      @(negedge clk);
      nw++;
    end
    chk("bp_words_before_flush", 64'(got_q.size() - wb), 64'(3));
    pulse_flush();
    wait_done(fb);
    mq.delete();
    mpush(64'h2_DEAD_BEEF_1234, 50);
    mpush(64'h1_5A5A_C3C3_0F0F, 50);
    mpush(64'h1, 1);
    mpush(64'h0, 1);
    chk("bp_words", 64'(got_q.size() - wb), 64'(4));
    for (int i = 0; i < 4; i++) chk_word($sformatf("bp_word%0d", i), wb + i, mword());
    chk("bp_bits_written", 64'(bus.bits_written), 64'(102));

    // Oversize inputs are consumed, flagged and dropped.
    do_reset();
    bus.out_ready = 1'b1;
    wb = got_q.size(); fb = fd_cnt;
    for (int i = 6; i < 11; i++) run_vec(i);
    pulse_flush();
    wait_done(fb);
    chk("ovs_words", 64'(got_q.size() - wb), 64'(1));
    chk_word("ovs_word0", wb, 32'hA5A5A500);
    chk("ovs_err_sticky", 64'(bus.err_oversize), 64'(1));

    // Mid-stream reset clears the sticky error and counters.
    bus.out_ready = 1'b0;
    send(vt[13]);
    do_reset();
    chk_reset_state("rst_mid");

    // Partial group flushed together with its second input.
    bus.out_ready = 1'b1;
    wb = got_q.size(); fb = fd_cnt; fpb = fd_pop_cnt;
    for (int i = 11; i < 13; i++) run_vec(i);
    wait_done(fb);
    chk("part_words", 64'(got_q.size() - wb), 64'(1));
    chk_word("part_word0", wb, 32'hFE064000);
    chk("part_bits_written", 64'(bus.bits_written), 64'(18));
    chk("part_flush_done", 64'(fd_cnt - fb), 64'(1));
    chk("part_done_on_pop", 64'(fd_pop_cnt - fpb), 64'(1));

    // Reset while stalled in FLUSH.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 13; i < 15; i++) run_vec(i);
    repeat (4) @(negedge clk);
    chk("mf_stalled_valid", 64'(bus.out_valid), 64'(1));
    fb = fd_cnt;
    do_reset();
    chk_reset_state("rst_flush");
    chk("mf_no_done", 64'(fd_cnt - fb), 64'(0));
    bus.out_ready = 1'b1;
    wb = got_q.size();
    run_vec(15);
    pulse_flush();
    wait_done(fb);
    chk("mf_words", 64'(got_q.size() - wb), 64'(1));
    chk_word("mf_word0", wb, 32'hC3000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ecg_bitstream_packer.md
Name: ecg_bitstream_packer

Overview:
- Parametrised successor to the single-ECG entropy encoder output stage.
- Accepts one variable-length encoded ECG per handshake (code plus deferred sign bits) and packs codes MSB-first into a bit buffer.
- After every NUM_ECG ECGs, appends the collected sign bits as one field.
- Emits fixed OUT_WIDTH words over a valid/ready interface, with backpressure, explicit flush with zero padding, and error flagging.

Parameters:
- CODE_WIDTH, 50: max encoded ECG length in bits.
- SIZE_WIDTH, 6: width of the code size field; must satisfy 2^SIZE_WIDTH > CODE_WIDTH.
- SIGN_WIDTH, 4: max sign bits per ECG.
- NUM_ECG, 4: ECGs per sign-append group.
- OUT_WIDTH, 32: output word width.
- BUF_WIDTH, 128: bit buffer depth; must satisfy BUF_WIDTH >= CODE_WIDTH + OUT_WIDTH and BUF_WIDTH >= NUM_ECG*SIGN_WIDTH + OUT_WIDTH.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: input ECG present.
- in_ready, output, 1: packer can accept an ECG.
- in_code, input, CODE_WIDTH: code, right-aligned; valid bits are [in_size-1:0], transmitted MSB first.
- in_size, input, SIZE_WIDTH: code length, 0..CODE_WIDTH.
- in_sign, input, SIGN_WIDTH: sign bits, right-aligned.
- in_sign_size, input, 3: sign bit count, 0..SIGN_WIDTH.
- flush_req, input, 1: pulse requesting a group close and pad to a word boundary.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts a word.
- out_data, output, OUT_WIDTH: packed word; earliest bit at the MSB.
- flush_done, output, 1: one-cycle pulse when a flush completes.
- err_oversize, output, 1: sticky error flag.
- bits_written, output, 32: count of code and sign bits appended; wraps modulo 2^32.

Behaviour:
- Reset: everything cleared, effective the cycle after rst is sampled high, including mid-flush.
  - Buffer, fill, sign buffer, sign_fill, ecg_cnt and bits_written are cleared to 0.
  - State returns to ACCEPT.
  - out_valid=0, out_data=0, flush_done=0, err_oversize=0.
  - in_ready=1 in the first cycle after reset.
- State machine: ACCEPT, APPEND_SIGN, FLUSH.
- in_ready is 1 only when state==ACCEPT and fill <= BUF_WIDTH-CODE_WIDTH.
- Input transfer happens when in_valid and in_ready are both 1.
  - The code is appended below the current fill, and fill += in_size.
  - in_sign[in_sign_size-1:0] is appended to the sign buffer, and sign_fill += in_sign_size.
  - ecg_cnt is incremented and bits_written += in_size.
  - in_size=0 is legal: the ECG is counted and no code bits are added.
- Oversize input: in_size > CODE_WIDTH or in_sign_size > SIGN_WIDTH.
  - The handshake completes but all data is discarded and the ECG is not counted.
  - err_oversize is set and stays high until reset.
- Output side:
  - out_valid = (fill >= OUT_WIDTH) or (state==FLUSH and fill > 0).
  - out_data is the top OUT_WIDTH buffer bits; bits below fill are forced to 0, which is the flush padding.
  - A pop shifts the buffer left by OUT_WIDTH and sets fill = max(fill-OUT_WIDTH, 0).
  - Push and pop in the same cycle are both applied: fill += in_size - popped.
  - out_data is held stable while out_valid=1 and out_ready=0.
- ACCEPT -> APPEND_SIGN: on the transfer that makes ecg_cnt==NUM_ECG.
- APPEND_SIGN:
  - Waits until the post-pop fill + sign_fill <= BUF_WIDTH.
  - Then appends the sign buffer, adds sign_fill to bits_written, and clears sign_fill and ecg_cnt.
  - Goes to FLUSH if a flush is pending, else to ACCEPT.
  - Takes one cycle when space is available. in_ready=0 while in this state.
- flush_req handling:
  - Sampled in ACCEPT only; ignored in other states.
  - If an input transfers in the same cycle, the input is appended first and the flush is then pending.
  - Pending flush with ecg_cnt>0 (partial group): go to APPEND_SIGN first, then FLUSH.
  - Pending flush with ecg_cnt==0: go directly to FLUSH.
- FLUSH:
  - Words are emitted until fill==0; in_ready=0.
  - On the cycle the last word pops, flush_done=1 for one cycle and the next state is ACCEPT.
  - A flush with fill==0 and ecg_cnt==0 pulses flush_done the next cycle with no words emitted.
- Stall: backpressure never loses or reorders bits. The stream order is codes in input order, then each group's sign field after the group's last code.

Test Plan:
1. Reset: assert rst for 2 cycles mid-stream, then release -> out_valid=0, fill=0, err_oversize=0, bits_written=0; in_ready=1 the next cycle.
2. Full group, one output word, then flush. Defaults (OUT_WIDTH=32, NUM_ECG=4).
   - Stimulus: codes 10'h3FF, 10'h000, 10'h2AA, 10'h155, each size 10 with sign 1'b1; then flush_req.
   - Required: word0 = 0xFFC00AA9, word1 = 0x55F00000, bits_written=44, flush_done pulses once.
3. Backpressure, size-50 codes with out_ready=0.
   - After the 1st code: fill=50, in_ready stays 1.
   - After the 2nd code: fill=100, in_ready=0.
   - Set out_ready=1 -> words pop; in_ready returns once fill <= 78; word content is bit-exact against a reference model.
4. Oversize: in_size=51 -> handshake completes, err_oversize=1 sticky, fill and ecg_cnt unchanged, and the next valid code packs normally.
5. Partial-group flush: 2 ECGs (size 7, signs 2 bits each), then flush_req in the same cycle as the 2nd input.
   - Required: 4 sign bits appended after 14 code bits, one word output 0x.... padded with zeros below bit 18.
   - flush_done=1 exactly one cycle, on the cycle that word pops.
6. Reset mid-FLUSH with out_ready=0 -> no flush_done, buffer empty, state ACCEPT, and subsequent packing starts from bit 0.
